cp0_exception_unit: RTL and testbench

//  CP0 responder for the mtc0/mfc0 and exception flags raised by instruction decode.

---
 rtl/cp0_exception_unit_pkg.sv | 45 ++++
 rtl/cp0_exception_unit_if.sv | 40 ++++
 rtl/cp0_exception_unit_timer.sv | 40 ++++
 rtl/cp0_exception_unit.sv | 124 ++++++++++++
 tb/tb_cp0_exception_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exception_unit_pkg.sv
// CP0 definitions shared by the exception unit: register numbers, ExcCodes,
// Status/Cause field positions and the exception vector.
package cp0_defs;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST = 32'h0040_0000;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_IP_LO  = 8;
  localparam int CAUSE_IP_HI  = 15;

  // Which address, if any, the committed exception loads into BadVAddr.
  typedef enum logic [1:0] {
    BV_KEEP = 2'd0,
    BV_PC   = 2'd1,
    BV_DATA = 2'd2
  } bv_src_e;

  typedef struct packed {
    logic    valid;
    logic [4:0] code;
    bv_src_e bv;
  } exc_t;

endpackage

// File: rtl/cp0_exception_unit_if.sv
// Commit-stage bundle between the pipeline (master) and CP0 (slave).
// No handshake: every flag is a single-cycle strobe for the committing
// instruction, and flush_o/exc_pc_o answer combinationally in that same cycle.
interface cp0_exception_unit_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  ext_int_i;
  logic [31:0] pc_i;
  logic        in_delay_i;
  logic [31:0] badvaddr_i;
  logic        adel_if_i;
  logic        ri_i;
  logic        ov_i;
  logic        sys_i;
  logic        bp_i;
  logic        adel_i;
  logic        ades_i;
  logic        eret_i;
  logic        flush_o;
  logic [31:0] exc_pc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, ext_int_i, pc_i, in_delay_i,
           badvaddr_i, adel_if_i, ri_i, ov_i, sys_i, bp_i, adel_i, ades_i, eret_i,
    input  rdata_o, flush_o, exc_pc_o, status_o, cause_o, epc_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, ext_int_i, pc_i, in_delay_i,
           badvaddr_i, adel_if_i, ri_i, ov_i, sys_i, bp_i, adel_i, ades_i, eret_i,
    output rdata_o, flush_o, exc_pc_o, status_o, cause_o, epc_o, timer_int_o
  );
endinterface

// File: rtl/cp0_exception_unit_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI is sticky
// until cleared, and an explicit Count write overrides the increment.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        compare_we,
  input  logic [31:0] compare_wdata,
  input  logic        ti_clear,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tog;

  always_ff @(posedge clk) begin
    if (rst) begin
      tog     <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      tog <= ~tog;
      if (count_we)
        count <= count_wdata;
      else if (tog)
        count <= count + 32'd1;
      if (compare_we)
        compare <= compare_wdata;
      // Compare==0 is the "timer disabled" value and never raises TI.
      if (ti_clear)
        ti <= 1'b0;
      else if ((count == compare) && (compare != 32'd0))
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: mtc0/mfc0 register file, exception prioritisation,
// one exception or eret commit per cycle with pipeline flush and redirect.
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = cp0_defs::EXC_VECTOR,
  parameter logic [31:0] STATUS_RST = cp0_defs::STATUS_RST
) (
  input  logic                 clk,
  input  logic                 rst,
  cp0_exception_unit_if.slave  bus
);
  import cp0_defs::*;

  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        cause_bd;
  logic [1:0]  cause_sw;
  logic [4:0]  cause_code;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [31:0] cause;
  logic        int_req;
  exc_t        exc;
  logic        eret_take;
  logic        wr_en;
  logic        count_we;
  logic        compare_we;

  // IP[7] merges the timer with the top hardware line; IP[1:0] are software bits.
  assign cause = {cause_bd, ti, 14'd0, bus.ext_int_i[5] | ti, bus.ext_int_i[4:0],
                  cause_sw, 1'b0, cause_code, 2'b00};

  assign int_req = status[STATUS_IE] & ~status[STATUS_EXL] &
                   (|(cause[CAUSE_IP_HI:CAUSE_IP_LO] & status[STATUS_IM_HI:STATUS_IM_LO]));

  always_comb begin
    exc = '{valid: 1'b1, code: EXC_INT, bv: BV_KEEP};
    if (int_req)             exc.code = EXC_INT;
    else if (bus.adel_if_i)  begin exc.code = EXC_ADEL; exc.bv = BV_PC;   end
    else if (bus.ri_i)       exc.code = EXC_RI;
    else if (bus.ov_i)       exc.code = EXC_OV;
    else if (bus.sys_i)      exc.code = EXC_SYS;
    else if (bus.bp_i)       exc.code = EXC_BP;
    else if (bus.adel_i)     begin exc.code = EXC_ADEL; exc.bv = BV_DATA; end
    else if (bus.ades_i)     begin exc.code = EXC_ADES; exc.bv = BV_DATA; end
    else                     exc.valid = 1'b0;
  end

  assign eret_take = bus.eret_i & ~exc.valid;
  // A faulting or returning instruction never retires its own mtc0.
  assign wr_en      = bus.we_i & ~exc.valid & ~eret_take;
  assign count_we   = wr_en && (bus.waddr_i == REG_COUNT);
  assign compare_we = wr_en && (bus.waddr_i == REG_COMPARE);

  cp0_timer u_timer (
    .clk           (clk),
    .rst           (rst),
    .count_we      (count_we),
    .count_wdata   (bus.wdata_i),
    .compare_we    (compare_we),
    .compare_wdata (bus.wdata_i),
    .ti_clear      (compare_we),
    .count         (count),
    .compare       (compare),
    .ti            (ti)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      status     <= STATUS_RST;
      epc        <= 32'd0;
      badvaddr   <= 32'd0;
      cause_bd   <= 1'b0;
      cause_sw   <= 2'b00;
      cause_code <= 5'd0;
    end else if (exc.valid) begin
      // A nested exception keeps the original return point.
      if (!status[STATUS_EXL]) begin
        epc      <= bus.in_delay_i ? (bus.pc_i - 32'd4) : bus.pc_i;
        cause_bd <= bus.in_delay_i;
      end
      status[STATUS_EXL] <= 1'b1;
      cause_code         <= exc.code;
      if (exc.bv == BV_PC)
        badvaddr <= bus.pc_i;
      else if (exc.bv == BV_DATA)
        badvaddr <= bus.badvaddr_i;
    end else if (eret_take) begin
      status[STATUS_EXL] <= 1'b0;
    end else if (wr_en) begin
      case (bus.waddr_i)
        REG_STATUS: begin
          status[STATUS_IM_HI:STATUS_IM_LO] <= bus.wdata_i[15:8];
          status[STATUS_EXL]                <= bus.wdata_i[1];
          status[STATUS_IE]                 <= bus.wdata_i[0];
        end
        REG_CAUSE: cause_sw <= bus.wdata_i[9:8];
        REG_EPC:   epc      <= bus.wdata_i;
        default:   ;
      endcase
    end
  end

  always_comb begin
    case (bus.raddr_i)
      REG_BADVADDR: bus.rdata_o = badvaddr;
      REG_COUNT:    bus.rdata_o = count;
      REG_COMPARE:  bus.rdata_o = compare;
      REG_STATUS:   bus.rdata_o = status;
      REG_CAUSE:    bus.rdata_o = cause;
      REG_EPC:      bus.rdata_o = epc;
      default:      bus.rdata_o = 32'd0;
    endcase
  end

  assign bus.flush_o     = exc.valid | eret_take;
  assign bus.exc_pc_o    = exc.valid ? EXC_VECTOR : epc;
  assign bus.status_o    = status;
  assign bus.cause_o     = cause;
  assign bus.epc_o       = epc;
  assign bus.timer_int_o = ti;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Bench for cp0_exception_unit: directed scenarios then random commits,
// every cycle compared against a behavioural CP0 model.
module tb_cp0_exception_unit;
  import cp0_defs::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cp0_exception_unit_if bus ();

  cp0_exception_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Architectural model state
  logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
  logic        m_ti, m_bd, m_half;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
    m_ti = 0; m_bd = 0; m_half = 0; m_sw = 0; m_code = 0;
  endtask

  function automatic logic [31:0] model_cause();
    logic [7:0] ip;
    ip = {bus.ext_int_i[5] | m_ti, bus.ext_int_i[4:0], m_sw};
    return {m_bd, m_ti, 14'd0, ip, 1'b0, m_code, 2'b00};
  endfunction

  // Walk the sources highest priority first; src is the winning index.
  task automatic model_pick(output logic v, output logic [4:0] code, output int src);
    logic [31:0] c;
    logic        req [8];
    logic [4:0]  codes [8];
    c = model_cause();
    req[0] = m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
    req[1] = bus.adel_if_i; req[2] = bus.ri_i;  req[3] = bus.ov_i;   req[4] = bus.sys_i;
    req[5] = bus.bp_i;      req[6] = bus.adel_i; req[7] = bus.ades_i;
    codes = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    v = 0; code = 0; src = -1;
    for (int i = 0; i < 8; i++)
      if (req[i] && !v) begin v = 1; code = codes[i]; src = i; end
  endtask

  function automatic logic [31:0] model_rdata();
    case (bus.raddr_i)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return model_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic v, take_eret, wr, ti_next;
    logic [4:0]  code;
    int          src;
    logic [31:0] next_count;
    if (rst) begin
      model_reset();
      return;
    end
    model_pick(v, code, src);
    take_eret = bus.eret_i & ~v;
    wr = bus.we_i & ~v & ~take_eret;
    next_count = m_half ? m_count + 1 : m_count;
    ti_next = m_ti | ((m_count == m_compare) && (m_compare != 0));
    if (wr && bus.waddr_i == 5'd11) begin m_compare = bus.wdata_i; ti_next = 0; end
    if (wr && bus.waddr_i == 5'd9) next_count = bus.wdata_i;
    m_count = next_count; m_half = ~m_half; m_ti = ti_next;
    if (v) begin
      if (!m_status[1]) begin
        m_epc = bus.in_delay_i ? bus.pc_i - 4 : bus.pc_i;
        m_bd  = bus.in_delay_i;
      end
      m_status[1] = 1; m_code = code;
      if (src == 1) m_badv = bus.pc_i;
      if (src == 6 || src == 7) m_badv = bus.badvaddr_i;
    end else if (take_eret) begin
      m_status[1] = 0;
    end else if (wr) begin
      case (bus.waddr_i)
        5'd12: begin m_status[15:8] = bus.wdata_i[15:8]; m_status[1:0] = bus.wdata_i[1:0]; end
        5'd13: m_sw = bus.wdata_i[9:8];
        5'd14: m_epc = bus.wdata_i;
        default: ;
      endcase
    end
  endtask

  task automatic sample();
    logic v, take_eret;
    logic [4:0] code;
    int src;
    @(negedge clk);
    model_pick(v, code, src);
    take_eret = bus.eret_i & ~v;
    check("flush", bus.flush_o, v | take_eret);
    if (v) check("exc_pc_vec", bus.exc_pc_o, EXC_VECTOR);
    else if (take_eret) check("exc_pc_eret", bus.exc_pc_o, m_epc);
    check("rdata", bus.rdata_o, model_rdata());
    check("status", bus.status_o, m_status);
    check("cause", bus.cause_o, model_cause());
    check("epc", bus.epc_o, m_epc);
    check("timer_int", bus.timer_int_o, m_ti);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    bus.we_i = 0; bus.waddr_i = 0; bus.wdata_i = 0; bus.ext_int_i = 0;
    bus.pc_i = 32'h8000_1000; bus.in_delay_i = 0; bus.badvaddr_i = 0;
    bus.adel_if_i = 0; bus.ri_i = 0; bus.ov_i = 0; bus.sys_i = 0;
    bus.bp_i = 0; bus.adel_i = 0; bus.ades_i = 0; bus.eret_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    set_idle();
    bus.we_i = 1; bus.waddr_i = a; bus.wdata_i = d;
    sample();
    advance();
  endtask

  task automatic rand_inputs();
    logic [4:0] regs [7];
    regs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    set_idle();
    rst = ($urandom_range(0, 149) == 0);
    bus.raddr_i = regs[$urandom_range(0, 6)];
    if ($urandom_range(0, 2) == 0) begin
      bus.we_i = 1; bus.waddr_i = regs[$urandom_range(0, 6)]; bus.wdata_i = $urandom;
      if (bus.waddr_i == 5'd11) bus.wdata_i = m_count + $urandom_range(0, 20);
    end
    if ($urandom_range(0, 7) == 0) bus.ext_int_i = 6'($urandom);
    bus.pc_i = $urandom & 32'hFFFF_FFFC;
    bus.in_delay_i = 1'($urandom);
    bus.badvaddr_i = $urandom;
    bus.adel_if_i = ($urandom_range(0, 15) == 0); bus.ri_i   = ($urandom_range(0, 15) == 0);
    bus.ov_i      = ($urandom_range(0, 15) == 0); bus.sys_i  = ($urandom_range(0, 15) == 0);
    bus.bp_i      = ($urandom_range(0, 15) == 0); bus.adel_i = ($urandom_range(0, 15) == 0);
    bus.ades_i    = ($urandom_range(0, 15) == 0); bus.eret_i = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    logic [31:0] count_seq [5];
    bit seen;
    count_seq = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2};
    rst = 1; set_idle(); bus.raddr_i = 5'd12;
    model_reset();
    advance(); advance();
    rst = 0;

    // Reset values and the half-rate Count
    bus.raddr_i = 5'd9;
    for (int i = 0; i < 5; i++) begin
      sample(); check("count_seq", bus.rdata_o, count_seq[i]); advance();
    end
    bus.raddr_i = 5'd12;
    sample(); check("status_rst", bus.rdata_o, 32'h0040_0000); advance();

    // Reserved instruction
    bus.ri_i = 1; bus.pc_i = 32'hBFC0_0100;
    sample(); check("ri_flush", bus.flush_o, 1); check("ri_vec", bus.exc_pc_o, 32'hBFC0_0380);
    advance();
    set_idle(); bus.raddr_i = 5'd14;
    sample(); check("ri_epc", bus.rdata_o, 32'hBFC0_0100);
    check("ri_code", bus.cause_o[6:2], 10); check("ri_exl", bus.status_o[1], 1);
    advance();

    // Syscall in delay slot, then nested overflow
    mtc0(5'd12, 32'h0);
    set_idle(); bus.sys_i = 1; bus.in_delay_i = 1; bus.pc_i = 32'h8000_0010;
    sample(); advance();
    set_idle(); sample();
    check("sys_epc", bus.epc_o, 32'h8000_000C); check("sys_bd", bus.cause_o[31], 1);
    check("sys_code", bus.cause_o[6:2], 8);
    advance();
    set_idle(); bus.ov_i = 1; bus.pc_i = 32'h8000_0200;
    sample(); advance();
    set_idle(); sample();
    check("nest_epc", bus.epc_o, 32'h8000_000C); check("nest_code", bus.cause_o[6:2], 12);
    advance();

    // Overflow beats ades; the same-cycle EPC write is dropped
    set_idle(); bus.ov_i = 1; bus.ades_i = 1; bus.badvaddr_i = 32'h1234_0003;
    bus.we_i = 1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h1234_5678;
    sample(); advance();
    set_idle(); sample();
    check("prio_code", bus.cause_o[6:2], 12); check("prio_epc", bus.epc_o, 32'h8000_000C);
    advance();

    // Timer interrupt
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    set_idle(); bus.raddr_i = 5'd13;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      sample();
      if (bus.timer_int_o === 1'b1) begin
        seen = 1;
        check("ti_flush", bus.flush_o, 1); check("ti_vec", bus.exc_pc_o, 32'hBFC0_0380);
      end
      advance();
    end
    check("ti_seen", 32'(seen), 1);
    sample(); check("ti_code", bus.rdata_o[6:2], 0); check("ti_exl", bus.status_o[1], 1);
    advance();
    mtc0(5'd11, 32'h100);
    set_idle(); sample(); check("ti_clear", bus.timer_int_o, 0); advance();

    // eret, then reset overriding an exception
    mtc0(5'd14, 32'h8000_0040);
    set_idle(); bus.eret_i = 1;
    sample(); check("eret_flush", bus.flush_o, 1); check("eret_pc", bus.exc_pc_o, 32'h8000_0040);
    advance();
    set_idle(); sample(); check("eret_exl", bus.status_o[1], 0); advance();
    rst = 1; bus.ri_i = 1;
    sample(); advance();
    rst = 0; set_idle(); bus.raddr_i = 5'd13;
    sample();
    check("rst_status", bus.status_o, 32'h0040_0000); check("rst_cause", bus.rdata_o, 0);
    check("rst_epc", bus.epc_o, 0);
    advance();

    // Random commits against the model
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      sample();
      advance();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
